// File: rtl/dut_check_pkg.sv
// Shared types and MISR arithmetic for the response checker and its stimulus-side LFSR twin.
package dut_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_CHECK,
        ST_DONE
    } chk_state_e;

    localparam int          MISR_MAX_W   = 64;
    localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;

    // Operands are carried at MISR_MAX_W bits so one function serves every WIDTH.
    function automatic logic [MISR_MAX_W-1:0] misr_step(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] data,
        input logic [MISR_MAX_W-1:0] poly,
        input int                    width
    );
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] nxt;
        logic                  msb;
        mask = (width >= MISR_MAX_W) ? '1 : ((MISR_MAX_W'(1) << width) - MISR_MAX_W'(1));
        msb  = |(sig & (MISR_MAX_W'(1) << (width - 1)));
        nxt  = sig << 1;
        if (msb) begin
            nxt = nxt ^ poly;
        end
        return (nxt ^ data) & mask;
    endfunction

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register; with data_i tied to 0 it is a plain Galois LFSR.
module misr_reg
    import dut_check_pkg::*;
#(
    parameter int                    WIDTH = 32,
    parameter logic [MISR_MAX_W-1:0] POLY  = MISR_MAX_W'(DEFAULT_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] sig_o
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load_i) begin
            sig_d = seed_i;
        end else if (en_i) begin
            sig_d = WIDTH'(misr_step(MISR_MAX_W'(sig_q), MISR_MAX_W'(data_i), POLY, WIDTH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/dut_response_checker.sv
// Compacts a fixed window of valid DUT responses into a MISR signature and checks it
// against a golden value. Optional CAPTURE stall watchdog: define CHECKER_TIMEOUT_EN.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | waiting for start since reset
//   ST_SETTLE  | ignoring resp while the observed DUT pipeline fills
//   ST_CAPTURE | folding valid samples into the MISR
//   ST_CHECK   | one cycle, registers signature == expected
//   ST_DONE    | result held; start begins a new run
module dut_response_checker
    import dut_check_pkg::*;
#(
    parameter int                    WIDTH   = 32,
    parameter int                    CHANNEL = 60,
    parameter int                    SETTLE  = 4,
    parameter logic [WIDTH-1:0]      SEED    = '0,
    parameter logic [MISR_MAX_W-1:0] POLY    = MISR_MAX_W'(DEFAULT_POLY)
`ifdef CHECKER_TIMEOUT_EN
    ,
    parameter int                    TIMEOUT = 256
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [WIDTH-1:0]               resp,
    input  logic                           resp_valid,
    input  logic [WIDTH-1:0]               expected,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
`ifdef CHECKER_TIMEOUT_EN
    output logic                           timeout,
`endif
    output logic [WIDTH-1:0]               signature,
    output logic [$clog2(CHANNEL+1)-1:0]   sample_cnt
);

    localparam int                CNT_W    = $clog2(CHANNEL + 1);
    localparam int                SET_W    = $clog2(SETTLE + 2);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CHANNEL - 1);
    localparam logic [SET_W-1:0]  SET_LOAD = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);

    chk_state_e       state_q, state_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic             misr_load;
    logic             misr_en;

`ifdef CHECKER_TIMEOUT_EN
    localparam int               TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_LOAD = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] idle_q, idle_d;
    logic            timeout_q, timeout_d;
`endif

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        misr_load = 1'b0;
        misr_en   = 1'b0;
`ifdef CHECKER_TIMEOUT_EN
        idle_d    = idle_q;
        timeout_d = timeout_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    misr_load = 1'b1;
                    cnt_d     = '0;
                    settle_d  = SET_LOAD;
                    pass_d    = 1'b0;
                    state_d   = (SETTLE > 0) ? ST_SETTLE : ST_CAPTURE;
`ifdef CHECKER_TIMEOUT_EN
                    idle_d    = TO_LOAD;
                    timeout_d = 1'b0;
`endif
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (resp_valid) begin
                    misr_en = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
`ifdef CHECKER_TIMEOUT_EN
                    idle_d  = TO_LOAD;
`endif
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_CHECK;
                    end
                end
`ifdef CHECKER_TIMEOUT_EN
                else if (idle_q == '0) begin
                    state_d   = ST_DONE;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    idle_d = idle_q - 1'b1;
                end
`endif
            end
            ST_CHECK: begin
                pass_d  = (signature == expected);
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            cnt_q    <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            pass_q   <= pass_d;
        end
    end

`ifdef CHECKER_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`endif

    misr_reg #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .load_i (misr_load),
        .en_i   (misr_en),
        .seed_i (SEED),
        .data_i (resp),
        .sig_o  (signature)
    );

    assign busy       = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE) || (state_q == ST_CHECK);
    assign done       = (state_q == ST_DONE);
    assign pass       = pass_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_dut_response_checker.sv
// Randomized bench for dut_response_checker: three instances (windows of 1, 2 and 60) share stimulus.
module tb_dut_response_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] resp = '0;
    logic        resp_valid = 1'b0;
    logic [31:0] expected = '0;

    logic        c1_busy, c1_done, c1_pass;
    logic [31:0] c1_sig;
    logic [0:0]  c1_cnt;
    logic        c2_busy, c2_done, c2_pass;
    logic [31:0] c2_sig;
    logic [1:0]  c2_cnt;
    logic        m_busy, m_done, m_pass;
    logic [31:0] m_sig;
    logic [5:0]  m_cnt;
`ifdef CHECKER_TIMEOUT_EN
    logic        c1_to, c2_to, m_to;
`endif

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    dut_response_checker #(.WIDTH(32), .CHANNEL(1), .SETTLE(0)) u_c1 (
        .clk(clk), .rst(rst), .start(start), .resp(resp), .resp_valid(resp_valid),
        .expected(expected), .busy(c1_busy), .done(c1_done), .pass(c1_pass),
`ifdef CHECKER_TIMEOUT_EN
        .timeout(c1_to),
`endif
        .signature(c1_sig), .sample_cnt(c1_cnt)
    );

    dut_response_checker #(.WIDTH(32), .CHANNEL(2), .SETTLE(0)) u_c2 (
        .clk(clk), .rst(rst), .start(start), .resp(resp), .resp_valid(resp_valid),
        .expected(expected), .busy(c2_busy), .done(c2_done), .pass(c2_pass),
`ifdef CHECKER_TIMEOUT_EN
        .timeout(c2_to),
`endif
        .signature(c2_sig), .sample_cnt(c2_cnt)
    );

    dut_response_checker #(
        .WIDTH(32), .CHANNEL(60), .SETTLE(4)
`ifdef CHECKER_TIMEOUT_EN
        , .TIMEOUT(16)
`endif
    ) u_main (
        .clk(clk), .rst(rst), .start(start), .resp(resp), .resp_valid(resp_valid),
        .expected(expected), .busy(m_busy), .done(m_done), .pass(m_pass),
`ifdef CHECKER_TIMEOUT_EN
        .timeout(m_to),
`endif
        .signature(m_sig), .sample_cnt(m_cnt)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: shift left, fold the polynomial in when the MSB falls out, xor the sample.
    function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [31:0] d);
        logic [32:0] wide;
        wide = {1'b0, s} * 2;
        return wide[31:0] ^ (wide[32] ? 32'h04C11DB7 : 32'h0) ^ d;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        start      = 1'b0;
        resp_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Drives one main-window run. mode 0: 0xAAAAAAAA on alternate cycles; mode 1: random data/valid.
    // abort_at >= 0 resets once that many samples are in; start_at pulses a start mid-run.
    task automatic run_window(input int mode, input int abort_at, input int start_at, input bit want_pass);
        logic [31:0] ref_sig;
        logic [31:0] d;
        int          taken;
        int          k;
        bit          v;
        ref_sig = 32'h0;
        taken   = 0;
        k       = 0;
        start   = 1'b1;
        cyc();
        start = 1'b0;
        check_val("main_busy_start", m_busy, 1);
        check_val("main_sig_seed", m_sig, 0);
        while (taken < 60 && k < 2000) begin
            v = (mode == 0) ? (k % 2 == 0) : ($urandom_range(0, 2) != 0);
            d = (mode == 0) ? 32'hAAAAAAAA : $urandom;
            resp_valid = v;
            resp       = d;
            start      = (k == start_at);
            cyc();
            start = 1'b0;
            if (k >= 4 && v) begin
                taken++;
                ref_sig = ref_step(ref_sig, d);
            end
            k++;
            check_val("main_cnt_run", m_cnt, taken);
            check_val("main_sig_run", m_sig, ref_sig);
            if (abort_at >= 0 && taken == abort_at) begin
                rst = 1'b1;
                #1;
                check_val("abort_busy", m_busy, 0);
                check_val("abort_done", m_done, 0);
                check_val("abort_pass", m_pass, 0);
                check_val("abort_sig", m_sig, 0);
                check_val("abort_cnt", m_cnt, 0);
                #9;
                rst        = 1'b0;
                resp_valid = 1'b0;
                return;
            end
        end
        resp_valid = 1'b0;
        expected   = want_pass ? ref_sig : (ref_sig ^ 32'h1);
        check_val("main_in_check_busy", m_busy, 1);
        check_val("main_in_check_done", m_done, 0);
        cyc();
        check_val("main_done", m_done, 1);
        check_val("main_busy_clr", m_busy, 0);
        check_val("main_pass", m_pass, want_pass);
        check_val("main_sig_final", m_sig, ref_sig);
        check_val("main_cnt_final", m_cnt, 60);
        cyc();
        cyc();
        check_val("main_hold_sig", m_sig, ref_sig);
        check_val("main_hold_done", m_done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] d;
        int          n;

        do_reset();
        check_val("rst_m_busy", m_busy, 0);
        check_val("rst_m_done", m_done, 0);
        check_val("rst_m_pass", m_pass, 0);
        check_val("rst_m_sig", m_sig, 0);
        check_val("rst_m_cnt", m_cnt, 0);

        // Single-sample window, no settle.
        expected = 32'hABCDEFAB;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_val("c1_busy", c1_busy, 1);
        resp = 32'hABCDEFAB;
        resp_valid = 1'b1;
        cyc();
        resp_valid = 1'b0;
        check_val("c1_done_early", c1_done, 0);
        check_val("c1_sig", c1_sig, ref_step(32'h0, 32'hABCDEFAB));
        cyc();
        check_val("c1_done", c1_done, 1);
        check_val("c1_pass", c1_pass, 1);
        check_val("c1_cnt", c1_cnt, 1);

        // Two-sample window: passing then failing golden value.
        do_reset();
        r = ref_step(ref_step(32'h0, 32'h1), 32'h0);
        for (int pass_run = 0; pass_run < 2; pass_run++) begin
            expected = (pass_run == 0) ? 32'h2 : 32'h3;
            start = 1'b1;
            cyc();
            start = 1'b0;
            check_val("c2_done_clr", c2_done, 0);
            check_val("c2_pass_clr", c2_pass, 0);
            resp = 32'h1;
            resp_valid = 1'b1;
            cyc();
            resp = 32'h0;
            cyc();
            resp_valid = 1'b0;
            cyc();
            check_val("c2_done", c2_done, 1);
            check_val("c2_sig", c2_sig, r);
            check_val("c2_pass", c2_pass, (pass_run == 0) ? 1 : 0);
        end

        // Full window with settle, then a random-data run expected to mismatch.
        do_reset();
        run_window(0, -1, -1, 1'b1);
        do_reset();
        run_window(1, -1, -1, 1'b0);

        // Reset mid-capture, then a clean full window.
        do_reset();
        run_window(1, 30, -1, 1'b1);
        check_val("abort_idle_done", m_done, 0);
        run_window(1, -1, -1, 1'b1);

        // Start ignored while busy; start with a valid sample in DONE restarts without capturing it.
        do_reset();
        run_window(1, -1, 20, 1'b1);
        start = 1'b1;
        resp_valid = 1'b1;
        resp = $urandom;
        cyc();
        start = 1'b0;
        resp_valid = 1'b0;
        check_val("restart_sig_seed", m_sig, 0);
        check_val("restart_cnt", m_cnt, 0);
        check_val("restart_done", m_done, 0);
        check_val("restart_busy", m_busy, 1);

`ifdef CHECKER_TIMEOUT_EN
        // Stall after 5 samples; watchdog ends the run 16 cycles after the last one.
        do_reset();
        r = 32'h0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        for (int i = 0; i < 5; i++) begin
            d = $urandom;
            resp = d;
            resp_valid = 1'b1;
            cyc();
            r = ref_step(r, d);
        end
        resp_valid = 1'b0;
        expected = r;
        n = 0;
        while (!m_done && n < 100) begin
            cyc();
            n++;
        end
        check_val("to_latency", n, 16);
        check_val("to_flag", m_to, 1);
        check_val("to_pass", m_pass, 0);
        check_val("to_cnt", m_cnt, 5);
        check_val("to_sig", m_sig, r);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_val("to_clr", m_to, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
